// File: rtl/lda_pkg.sv
// Shared types and constants for the line-drawing pipeline and its
// pixel write-back stage.
package lda_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int COLOUR_W  = 3;
    localparam int FB_ADDR_W = 17;

    // One pixel as produced by the line drawer.
    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // Output stage state: nothing presented, or a write held on the port.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small circular FIFO of pixels. Head entry is visible combinationally on
// rd_data; push into a full FIFO and pop from an empty one are ignored.
module pixel_fifo
    import lda_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  pixel_t           wr_data,
    output pixel_t           rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    pixel_t           store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = store[rd_ptr];

    // Storage array: data only, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Clips the line drawer's pixel stream to the visible screen, buffers the
// surviving pixels and writes them to the framebuffer at y*320 + x through a
// stallable write port.
module pixel_write_buffer #(
    parameter int SCREEN_W   = lda_pkg::SCREEN_W,
    parameter int SCREEN_H   = lda_pkg::SCREEN_H,
    parameter int COLOUR_W   = lda_pkg::COLOUR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = lda_pkg::FB_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8:0]          in_x,
    input  logic [7:0]          in_y,
    input  logic [COLOUR_W-1:0] in_colour,
    output logic                mem_we,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_data,
    output logic                busy,
    output logic [15:0]         plotted_count,
    output logic [15:0]         clipped_count
);

    import lda_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [X_W-1:0] X_LIMIT = X_W'(SCREEN_W);
    localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(SCREEN_H);

    // y*320 + x as two shifts and adds, done at full address width.
    function automatic logic [ADDR_W-1:0] calc_addr(input logic [Y_W-1:0] y,
                                                    input logic [X_W-1:0] x);
        logic [ADDR_W-1:0] yw;
        logic [ADDR_W-1:0] xw;
        yw = ADDR_W'(y);
        xw = ADDR_W'(x);
        return (yw << 8) + (yw << 6) + xw;
    endfunction

    // Event counters stick at all-ones rather than wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    wr_state_t        state;
    wr_state_t        next_state;
    logic             accept;
    logic             clip;
    logic             push;
    logic             pop;
    logic             write_done;
    pixel_t           in_pixel;
    pixel_t           head;
    logic [CNT_W-1:0] count;
    logic             fifo_full;
    logic             fifo_empty;

    assign in_ready   = (count != CNT_W'(FIFO_DEPTH));
    assign accept     = in_valid && in_ready;
    assign clip       = (in_x >= X_LIMIT) || (in_y >= Y_LIMIT);
    assign push       = accept && !clip;
    assign in_pixel   = '{x: in_x, y: in_y, colour: in_colour};
    assign mem_we     = (state == S_WRITE);
    assign write_done = (state == S_WRITE) && mem_ready;
    assign busy       = (count != '0) || (state == S_WRITE);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_pixel),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Load the output stage whenever it is empty or its write just completed.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = S_WRITE;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Address and colour are captured at pop and held until the write completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_data <= '0;
        end else if (pop) begin
            mem_addr <= calc_addr(head.y, head.x);
            mem_data <= COLOUR_W'(head.colour);
        end
    end

    // Completed writes and clipped inputs are counted independently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plotted_count <= '0;
            clipped_count <= '0;
        end else begin
            if (write_done) begin
                plotted_count <= sat_inc(plotted_count);
            end
            if (accept && clip) begin
                clipped_count <= sat_inc(clipped_count);
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer. Inputs change and outputs are
// sampled on the falling edge; the design acts on the rising edge.
module tb_pixel_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_x;
    logic [7:0]  in_y;
    logic [2:0]  in_colour;
    logic        mem_we;
    logic        mem_ready;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        busy;
    logic [15:0] plotted_count;
    logic [15:0] clipped_count;

    int n_checks = 0;
    int n_pass   = 0;

    pixel_write_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_colour     (in_colour),
        .mem_we        (mem_we),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .busy          (busy),
        .plotted_count (plotted_count),
        .clipped_count (clipped_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v, input int x, input int y, input int c);
        in_valid  = v;
        in_x      = 9'(x);
        in_y      = 8'(y);
        in_colour = 3'(c);
    endtask

    // Reset held across one rising edge, released on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 0, 0, 0);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int exp_bp_addr [5] = '{6410, 6731, 7052, 7373, 7694};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_colour = '0;
        mem_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_plotted", plotted_count, 0);
        check("rst_clipped", clipped_count, 0);

        // Single pixel (5,2) colour 5 -> address 645
        mem_ready = 1'b1;
        drive(1'b1, 5, 2, 5);
        @(negedge clk);
        drive(1'b0, 0, 0, 0);
        check("single_we_early", mem_we, 0);
        check("single_busy_fifo", busy, 1);
        @(negedge clk);
        check("single_we", mem_we, 1);
        check("single_addr", mem_addr, 645);
        check("single_data", mem_data, 5);
        @(negedge clk);
        check("single_we_done", mem_we, 0);
        check("single_plotted", plotted_count, 1);
        check("single_busy_done", busy, 0);

        // Clipping: two off-screen, one at the bottom-right corner
        do_reset();
        mem_ready = 1'b1;
        drive(1'b1, 320, 0, 1);
        @(negedge clk);
        drive(1'b1, 0, 240, 2);
        @(negedge clk);
        drive(1'b1, 319, 239, 6);
        @(negedge clk);
        drive(1'b0, 0, 0, 0);
        check("clip_count", clipped_count, 2);
        check("clip_no_write_yet", mem_we, 0);
        @(negedge clk);
        check("clip_we", mem_we, 1);
        check("clip_addr", mem_addr, 76799);
        check("clip_data", mem_data, 6);
        @(negedge clk);
        check("clip_we_done", mem_we, 0);
        check("clip_plotted", plotted_count, 1);
        check("clip_count_final", clipped_count, 2);

        // Back-pressure: five pixels fill output stage plus FIFO
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_ready_%0d", i), in_ready, 1);
            drive(1'b1, 10 + i, 20 + i, i);
            @(negedge clk);
        end
        drive(1'b0, 0, 0, 0);
        check("bp_full_ready", in_ready, 0);
        check("bp_stall_we", mem_we, 1);
        check("bp_stall_addr", mem_addr, 6410);
        @(negedge clk);
        check("bp_hold_we", mem_we, 1);
        check("bp_hold_addr", mem_addr, 6410);
        check("bp_hold_data", mem_data, 0);
        check("bp_hold_plotted", plotted_count, 0);
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_we_%0d", i), mem_we, 1);
            check($sformatf("bp_addr_%0d", i), mem_addr, exp_bp_addr[i]);
            check($sformatf("bp_data_%0d", i), mem_data, i);
            @(negedge clk);
        end
        check("bp_we_done", mem_we, 0);
        check("bp_plotted", plotted_count, 5);
        check("bp_busy_done", busy, 0);

        // Throughput: ten pixels along y=0, one write per cycle
        do_reset();
        mem_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k >= 2) begin
                check($sformatf("tp_we_%0d", k - 2), mem_we, 1);
                check($sformatf("tp_addr_%0d", k - 2), mem_addr, k - 2);
            end
            if (k < 10) begin
                check($sformatf("tp_ready_%0d", k), in_ready, 1);
                drive(1'b1, k, 0, 3);
            end else begin
                drive(1'b0, 0, 0, 0);
            end
            @(negedge clk);
        end
        check("tp_we_done", mem_we, 0);
        check("tp_plotted", plotted_count, 10);

        // Clipped input in the same cycle as a write completion
        do_reset();
        mem_ready = 1'b1;
        drive(1'b1, 1, 1, 7);
        @(negedge clk);
        drive(1'b0, 0, 0, 0);
        @(negedge clk);
        check("sim_we", mem_we, 1);
        check("sim_addr", mem_addr, 321);
        drive(1'b1, 400, 0, 0);
        @(negedge clk);
        drive(1'b0, 0, 0, 0);
        check("sim_plotted", plotted_count, 1);
        check("sim_clipped", clipped_count, 1);

        // Mid-operation asynchronous reset
        do_reset();
        mem_ready = 1'b0;
        drive(1'b1, 300, 100, 1);
        @(negedge clk);
        drive(1'b1, 301, 100, 2);
        @(negedge clk);
        drive(1'b1, 302, 100, 3);
        @(negedge clk);
        drive(1'b1, 500, 0, 0);
        @(negedge clk);
        drive(1'b0, 0, 0, 0);
        check("mr_we_before", mem_we, 1);
        check("mr_clipped_before", clipped_count, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mr_we", mem_we, 0);
        check("mr_busy", busy, 0);
        check("mr_ready", in_ready, 1);
        check("mr_clipped", clipped_count, 0);
        check("mr_addr", mem_addr, 0);
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mr_no_stale_%0d", k), mem_we, 0);
        end
        check("mr_plotted", plotted_count, 0);

        // Saturation of the clipped counter
        do_reset();
        drive(1'b1, 320, 0, 0);
        for (int k = 0; k < 65540; k++) begin
            @(negedge clk);
        end
        drive(1'b0, 0, 0, 0);
        check("sat_clipped", clipped_count, 16'hFFFF);
        check("sat_plotted", plotted_count, 0);
        check("sat_we", mem_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
